mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
Multicycle control unit that sequences the shared Mips_cpu datapath: one ALU, one unified instruction/data memory, and one register file, reused across cycles.
- Moore FSM that decodes Opcode and issues per-state datapath enables and mux selects.
- Stalls on a memory-ready handshake.
- Pulses one retire strobe per completed instruction.
- Sits between the instruction register and the datapath muxes inside Mips_cpu.

Parameters:
- STATE_W, 4, width of the State debug output. Must be 4 or more.
- RETIRE_CNT_W, 32, width of the retired-instruction counter.

Ports:
- ClkIn  in  1  system clock; all state changes on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- Opcode  in  6  IR[31:26] of the held instruction.
- Zero  in  1  ALU zero flag, valid in BRANCH.
- MemReady  in  1  memory done; completes the current MemRead or MemWrite this cycle.
- PCEn  out  1  PC load enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  write register select: 1 = rd, 0 = rt.
- MemtoReg  out  1  write data select: 1 = MDR, 0 = ALUOut.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A.
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = decode funct.
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- Retire  out  1  one-cycle pulse when an instruction completes.
- IllegalOp  out  1  one-cycle pulse in DECODE on an unsupported opcode.
- RetireCnt  out  RETIRE_CNT_W  count of retired instructions; wraps.
- State  out  STATE_W  current state encoding, for debug.

Behaviour:
- Reset: synchronous, active-high. While Rst=1, at each rising edge: State becomes FETCH(0) and RetireCnt becomes 0.
- While Rst=1, PCEn, MemRead, MemWrite, IRWrite, RegWrite, Retire and IllegalOp are forced to 0 combinationally. All other outputs show their FETCH values.
- Rst asserted mid-instruction abandons it: no Retire pulse, no partial write after the reset edge.
- Outputs are decoded combinationally from State, except PCEn (see FETCH and BRANCH). Unlisted outputs are 0.
- State encodings and actions:
  - FETCH=0: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=MemReady, PCEn=MemReady. Stay while MemReady=0; go to DECODE when MemReady=1.
  - DECODE=1: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXEC
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - 001000 (addi) -> ADDIEX
    - any other opcode -> FETCH, with IllegalOp=1 and no Retire.
  - MEMADR=2: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: MEMRD if Opcode=lw, else MEMWR.
  - MEMRD=3: IorD=1, MemRead=1. Stay until MemReady=1, then go to MEMWB.
  - MEMWB=4: RegDst=0, MemtoReg=1, RegWrite=1, Retire=1. Next: FETCH.
  - MEMWR=5: IorD=1, MemWrite=1. Stay until MemReady=1. On that cycle Retire=1 and next state is FETCH.
  - EXEC=6: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - ALUWB=7: RegDst=1, MemtoReg=0, RegWrite=1, Retire=1. Next: FETCH.
  - BRANCH=8: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCEn=Zero, Retire=1. Next: FETCH.
  - JUMP=9: PCSource=10, PCEn=1, Retire=1. Next: FETCH.
  - ADDIEX=10: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: ADDIWB.
  - ADDIWB=11: RegDst=0, MemtoReg=0, RegWrite=1, Retire=1. Next: FETCH.
  - Encodings 12-15 are unreachable. If entered, outputs are 0 and the next state is FETCH.
- Latency from FETCH entry to Retire, with MemReady always 1:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type and addi: 4 cycles
  - beq and j: 3 cycles
  - Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds 1 cycle.
- Handshake: MemRead and MemWrite stay asserted and stable until MemReady is sampled high. MemRead and MemWrite are never both 1. MemReady is ignored in all other states.
- Opcode is sampled only in DECODE and MEMADR. The IR is stable in those states because IRWrite is only asserted in FETCH.
- RetireCnt increments by 1 on every Retire cycle and wraps from all-ones to 0.

Test Plan:
- Reset and idle: hold Rst=1 for 3 cycles with MemReady=1 -> State=0, RetireCnt=0, PCEn=IRWrite=MemRead=0. After release, the first FETCH cycle shows MemRead=1 and PCEn=1.
- lw with memory wait: Opcode=100011, MemReady=0 for 2 cycles in MEMRD -> state path 0,1,2,3,3,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; one Retire; RetireCnt=1.
- beq taken vs not taken: Opcode=000100 with Zero=1 -> PCEn=1 and PCSource=01 in BRANCH. With Zero=0 -> PCEn=0. Both cases return to FETCH in 3 cycles with one Retire each.
- sw and R-type back to back, MemReady=1 -> sw retires in cycle 4 with MemWrite=1 exactly 1 cycle; the R-type reaches ALUWB with RegDst=1 and ALUOp=10 in EXEC; RetireCnt=2.
- Illegal opcode 111111 -> IllegalOp pulses once in DECODE, next State=0, no Retire, RetireCnt unchanged.
- Reset mid-instruction: assert Rst in MEMRD -> next State=0, no RegWrite, no Retire, RetireCnt=0. Separately, preload the counter to all-ones (RETIRE_CNT_W=4) and retire one instruction -> RetireCnt=0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
// Moore control FSM for the multicycle MIPS datapath. One ALU, one unified
// memory and one register file are shared across cycles. The FSM decodes the
// held opcode and sequences the datapath enables and mux selects. It stalls on
// the memory-ready handshake and pulses Retire once per completed instruction.
//
// Ports:
//   ClkIn      in   system clock, rising edge
//   Rst        in   synchronous active-high reset
//   Opcode     in   IR[31:26] of the held instruction
//   Zero       in   ALU zero flag, used in BRANCH
//   MemReady   in   completes the pending memory read or write this cycle
//   PCEn       out  PC load enable
//   IorD       out  memory address select (0 = PC, 1 = ALUOut)
//   MemRead    out  memory read request
//   MemWrite   out  memory write request
//   IRWrite    out  instruction register load
//   RegDst     out  write register select (1 = rd, 0 = rt)
//   MemtoReg   out  write data select (1 = MDR, 0 = ALUOut)
//   RegWrite   out  register file write
//   ALUSrcA    out  ALU A select (0 = PC, 1 = A)
//   ALUSrcB    out  ALU B select (00 B, 01 4, 10 SignImm, 11 SignImm<<2)
//   ALUOp      out  00 add, 01 sub, 10 decode funct
//   PCSource   out  00 ALU, 01 ALUOut, 10 jump target
//   Retire     out  one-cycle pulse per completed instruction
//   IllegalOp  out  one-cycle pulse in DECODE on an unsupported opcode
//   RetireCnt  out  wrapping count of retired instructions
//   State      out  current state encoding, for debug
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter int unsigned STATE_W      = 4,
  parameter int unsigned RETIRE_CNT_W = 32
) (
  input  logic                    ClkIn,
  input  logic                    Rst,
  input  logic [5:0]              Opcode,
  input  logic                    Zero,
  input  logic                    MemReady,
  output logic                    PCEn,
  output logic                    IorD,
  output logic                    MemRead,
  output logic                    MemWrite,
  output logic                    IRWrite,
  output logic                    RegDst,
  output logic                    MemtoReg,
  output logic                    RegWrite,
  output logic                    ALUSrcA,
  output logic [1:0]              ALUSrcB,
  output logic [1:0]              ALUOp,
  output logic [1:0]              PCSource,
  output logic                    Retire,
  output logic                    IllegalOp,
  output logic [RETIRE_CNT_W-1:0] RetireCnt,
  output logic [STATE_W-1:0]      State
);

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  state_t                  w_dec_state;
  logic [RETIRE_CNT_W-1:0] r_retire_cnt;

  // State register and retired-instruction counter
  always_ff @(posedge ClkIn) begin
    if (Rst) begin
      r_state      <= S_FETCH;
      r_retire_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (Retire) begin
        r_retire_cnt <= r_retire_cnt + RETIRE_CNT_W'(1);
      end
    end
  end

  // Next-state and per-state datapath control decode
  always_comb begin
    PCEn      = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_B;
    ALUOp     = ALUOP_ADD;
    PCSource  = PCSRC_ALU;
    Retire    = 1'b0;
    IllegalOp = 1'b0;
    w_next    = S_FETCH;

    // During reset the outputs show FETCH values; strobes are masked below
    w_dec_state = Rst ? S_FETCH : r_state;

    case (w_dec_state)
      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        IRWrite  = MemReady;
        PCEn     = MemReady;
        w_next   = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMMSH;
        case (Opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYP:      w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDIEX;
          default: begin
            IllegalOp = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        w_next  = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        w_next  = MemReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        Retire   = 1'b1;
      end
      S_MEMWR: begin
        // A store retires on the cycle memory accepts it
        IorD     = 1'b1;
        MemWrite = 1'b1;
        Retire   = MemReady;
        w_next   = MemReady ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_B;
        ALUOp   = ALUOP_FUNCT;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        Retire   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = SRCB_B;
        ALUOp    = ALUOP_SUB;
        PCSource = PCSRC_ALUOUT;
        PCEn     = Zero;
        Retire   = 1'b1;
      end
      S_JUMP: begin
        PCSource = PCSRC_JUMP;
        PCEn     = 1'b1;
        Retire   = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        Retire   = 1'b1;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase

    // Reset abandons the instruction: no writes, requests or retire
    if (Rst) begin
      PCEn      = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      Retire    = 1'b0;
      IllegalOp = 1'b0;
      w_next    = S_FETCH;
    end
  end

  assign RetireCnt = r_retire_cnt;
  assign State     = STATE_W'(r_state);

endmodule
